// File: rtl/d_latch_loader_pkg.sv
// Package for d_latch_loader.
// Holds the sequencer state encoding, the default timing constants and the
// helper that sizes the shared interval counter.
package d_latch_loader_pkg;

  // Sequencer states. One c pulse is framed by SETUP, PULSE and HOLD intervals.
  // WAIT_DAV then waits for the producer to release dav_.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSetup   = 3'd1,
    StPulse   = 3'd2,
    StHold    = 3'd3,
    StWaitDav = 3'd4
  } state_e;

  // Default geometry and timing.
  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefSetupCyc = 2;
  localparam int unsigned DefPulseCyc = 3;
  localparam int unsigned DefHoldCyc  = 2;

  // The counter must hold the largest interval value.
  // It counts down from N and expires at 1.
  function automatic int unsigned cnt_width(input int unsigned setup_cyc,
                                            input int unsigned pulse_cyc,
                                            input int unsigned hold_cyc);
    int unsigned m;
    m = setup_cyc;
    if (pulse_cyc > m) m = pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/d_latch_loader_cycle_counter.sv
// cycle_counter: down counter shared by the setup, pulse and hold intervals.
//
// Ports
//   clock    in   system clock, rising edge
//   reset_   in   synchronous active-low reset (counter cleared to 0)
//   load     in   load load_val at the next edge (has priority over counting)
//   load_val in   interval length N (N >= 1)
//   expire   out  high while the count is 1, i.e. on the last cycle of the interval
//
// After loading N, expire is high on the N-th following cycle. The count parks
// at 0 once it has run out.
module cycle_counter
  import d_latch_loader_pkg::*;
#(
  parameter int unsigned CNT_W = cnt_width(DefSetupCyc, DefPulseCyc, DefHoldCyc)
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/d_latch_loader.sv
// d_latch_loader: upstream stage for a WIDTH-bit bank of D latches sharing one c line.
//
// A word is taken from the producer over a 4-phase dav_/rfd handshake.
// The word is driven onto d. The stage then raises c for PULSE_CYC cycles.
// d is stable for SETUP_CYC cycles before c rises and for HOLD_CYC cycles after c
// falls, so every latch sees clean setup/hold around the closing edge of c.
//
// Ports
//   clock      in   system clock, all state changes on the rising edge
//   reset_     in   synchronous active-low reset
//   dav_       in   producer data valid, active low
//   data_in    in   producer data, sampled only at the capture edge
//   rfd        out  ready for data (registered)
//   d          out  latch-bank d bus (registered)
//   c          out  latch-bank shared control (registered)
//   preclear_  out  latch-bank clear, active low; only when LATCH_CLEAR_EN is defined
//
// Build option
//   LATCH_CLEAR_EN : adds preclear_. It is low at every edge with reset_=0 and for
//                    one further cycle after reset_ returns high. This clears the
//                    bank on reset. New captures are blocked while it is low.
module d_latch_loader
  import d_latch_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned SETUP_CYC = DefSetupCyc,
  parameter int unsigned PULSE_CYC = DefPulseCyc,
  parameter int unsigned HOLD_CYC  = DefHoldCyc
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             dav_,
  input  logic [WIDTH-1:0] data_in,
  output logic             rfd,
  output logic [WIDTH-1:0] d,
  output logic             c
`ifdef LATCH_CLEAR_EN
  ,
  output logic             preclear_
`endif
);

  localparam int unsigned CntW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC);
  localparam logic [CntW-1:0] PulseLd = CntW'(PULSE_CYC);
  localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             c_q, c_d;
  logic             rfd_q, rfd_d;

  logic             cnt_load;
  logic [CntW-1:0]  cnt_val;
  logic             cnt_expire;
  logic             capture_ok;

  // One counter times all three intervals. Each interval reloads it on the
  // cycle the previous one expires, so the intervals run back to back.
  cycle_counter #(
    .CNT_W (CntW)
  ) u_cycle_counter (
    .clock    (clock),
    .reset_   (reset_),
    .load     (cnt_load),
    .load_val (cnt_val),
    .expire   (cnt_expire)
  );

`ifdef LATCH_CLEAR_EN
  logic preclear_q;
  logic reset_q;

  // reset_q remembers last edge's reset_. preclear_ therefore stays low for one
  // cycle past the first edge that sees reset_ high again.
  always_ff @(posedge clock) begin
    reset_q    <= reset_;
    preclear_q <= reset_ & reset_q;
  end

  assign preclear_  = preclear_q;
  assign capture_ok = preclear_q;
`else
  assign capture_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    c_d      = c_q;
    rfd_d    = rfd_q;
    cnt_load = 1'b0;
    cnt_val  = '0;

    case (state_q)
      StIdle: begin
        if (!dav_ && capture_ok) begin
          d_d      = data_in;
          rfd_d    = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = SetupLd;
          state_d  = StSetup;
        end
      end

      // dav_ is deliberately ignored in the timed states. An early release
      // must not cut the pulse or its hold window short.
      StSetup: begin
        if (cnt_expire) begin
          c_d      = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = PulseLd;
          state_d  = StPulse;
        end
      end

      StPulse: begin
        if (cnt_expire) begin
          c_d      = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = HoldLd;
          state_d  = StHold;
        end
      end

      StHold: begin
        if (cnt_expire) begin
          state_d = StWaitDav;
        end
      end

      // Second half of the 4-phase handshake. A producer still holding dav_
      // low stalls here, so it cannot start a second transfer.
      StWaitDav: begin
        if (dav_) begin
          rfd_d   = 1'b1;
          state_d = StIdle;
        end
      end

      default: begin
        c_d     = 1'b0;
        rfd_d   = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= StIdle;
      d_q     <= '0;
      c_q     <= 1'b0;
      rfd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      c_q     <= c_d;
      rfd_q   <= rfd_d;
    end
  end

  assign d   = d_q;
  assign c   = c_q;
  assign rfd = rfd_q;

endmodule
